// File: rtl/uart_pkg.sv
// Shared UART definitions: clock/oversampling constants, baud divisor table
// and the receive FSM state encoding.
package uart_pkg;

  localparam int unsigned CLK_FREQ   = 50_000_000;
  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned DIV_W      = 14;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  function automatic int unsigned baud_rate(input logic [2:0] sel);
    case (sel)
      3'b000:  baud_rate = 300;
      3'b001:  baud_rate = 1200;
      3'b010:  baud_rate = 4800;
      3'b011:  baud_rate = 9600;
      3'b100:  baud_rate = 19200;
      3'b101:  baud_rate = 38400;
      3'b110:  baud_rate = 57600;
      default: baud_rate = 115200;
    endcase
  endfunction

  // Clocks per oversample tick, rounded to nearest. Only ever called with
  // constant arguments so it folds into a lookup table.
  function automatic logic [DIV_W-1:0] baud_divisor(input logic [2:0] sel);
    int unsigned den;
    den          = OVERSAMPLE * baud_rate(sel);
    baud_divisor = DIV_W'((CLK_FREQ + den / 2) / den);
  endfunction

endpackage

// File: rtl/baud_controller.sv
// 16x oversample tick generator shared by the UART transmitter and receiver.
module baud_controller
  import uart_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] baud_select_i,
  input  logic       clear_i,
  output logic       tick_o
);

  logic [DIV_W-1:0] div_rom [8];
  logic [DIV_W-1:0] limit;
  logic [DIV_W-1:0] cnt_q, cnt_d;

  for (genvar g = 0; g < 8; g++) begin : g_div_rom
    assign div_rom[g] = baud_divisor(3'(g));
  end

  assign limit  = div_rom[baud_select_i] - DIV_W'(1);
  assign tick_o = ~clear_i & (cnt_q == limit);

  always_comb begin
    cnt_d = cnt_q + DIV_W'(1);
    if (clear_i || tick_o) cnt_d = '0;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_receiver.sv
// UART receive stage: 8 data bits LSB first, even parity, one stop bit,
// 16x oversampled with mid-bit sampling.
module uart_receiver
  import uart_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       RxD,
  input  logic [2:0] baud_select,
  input  logic       Rx_EN,
  output logic [7:0] Rx_DATA,
  output logic       Rx_VALID,
  output logic       Rx_PERROR,
  output logic       Rx_FERROR
);

  logic       rxd_meta_q, rxd_sync_q, rxd_prev_q;
  rx_state_e  state_q, state_d;
  logic [3:0] tick_cnt_q, tick_cnt_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       parity_q, parity_d;
  logic [2:0] baud_sel_q, baud_sel_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       perr_q, perr_d;
  logic       ferr_q, ferr_d;

  logic       tick, fall, start_accept, mid_bit, parity_err;

  // The frame's divisor is latched while idle, so a baud change mid-frame
  // only affects the next frame.
  baud_controller u_baud (
    .clk           (clk),
    .rst_n         (reset),
    .baud_select_i (baud_sel_q),
    .clear_i       (~Rx_EN | start_accept),
    .tick_o        (tick)
  );

  assign fall         = rxd_prev_q & ~rxd_sync_q;
  assign start_accept = (state_q == ST_IDLE) & Rx_EN & fall;
  assign mid_bit      = tick & (tick_cnt_q == ((state_q == ST_START) ? 4'd7 : 4'd15));
  assign parity_err   = (^shift_q) ^ parity_q;

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a variable unassigned and infers a latch.
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    baud_sel_d = baud_sel_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    perr_d     = perr_q;
    ferr_d     = ferr_q;

    if (!Rx_EN) begin
      state_d    = ST_IDLE;
      tick_cnt_d = '0;
      bit_cnt_d  = '0;
    end else begin
      if (tick) tick_cnt_d = mid_bit ? 4'd0 : tick_cnt_q + 4'd1;

      unique case (state_q)
        ST_IDLE: begin
          tick_cnt_d = '0;
          bit_cnt_d  = '0;
          baud_sel_d = baud_select;
          if (start_accept) state_d = ST_START;
        end
        ST_START: begin
          if (mid_bit) begin
            if (rxd_sync_q) begin
              state_d = ST_IDLE;
            end else begin
              state_d = ST_DATA;
              perr_d  = 1'b0;
              ferr_d  = 1'b0;
            end
          end
        end
        ST_DATA: begin
          if (mid_bit) begin
            shift_d   = {rxd_sync_q, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
          end
        end
        ST_PARITY: begin
          if (mid_bit) begin
            parity_d = rxd_sync_q;
            state_d  = ST_STOP;
          end
        end
        ST_STOP: begin
          if (mid_bit) begin
            data_d  = shift_q;
            perr_d  = parity_err;
            ferr_d  = ~rxd_sync_q;
            valid_d = rxd_sync_q & ~parity_err;
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // Synchronizer resets to the idle line level so release never looks
      // like a start edge.
      rxd_meta_q <= 1'b1;
      rxd_sync_q <= 1'b1;
      rxd_prev_q <= 1'b1;
      state_q    <= ST_IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      baud_sel_q <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      rxd_meta_q <= RxD;
      rxd_sync_q <= rxd_meta_q;
      rxd_prev_q <= rxd_sync_q;
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      baud_sel_q <= baud_sel_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
    end
  end

  assign Rx_DATA   = data_q;
  assign Rx_VALID  = valid_q;
  assign Rx_PERROR = perr_q;
  assign Rx_FERROR = ferr_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: scoreboarded valid frames plus
// directed error, glitch, reset, baud-change and enable-abort scenarios.
`timescale 1ns/1ps
module tb_uart_receiver;

  logic       clk = 1'b0;
  logic       reset;
  logic       RxD;
  logic [2:0] baud_select;
  logic       Rx_EN;
  logic [7:0] Rx_DATA;
  logic       Rx_VALID;
  logic       Rx_PERROR;
  logic       Rx_FERROR;

  always #10 clk = ~clk;

  uart_receiver dut (
    .clk         (clk),
    .reset       (reset),
    .RxD         (RxD),
    .baud_select (baud_select),
    .Rx_EN       (Rx_EN),
    .Rx_DATA     (Rx_DATA),
    .Rx_VALID    (Rx_VALID),
    .Rx_PERROR   (Rx_PERROR),
    .Rx_FERROR   (Rx_FERROR)
  );

  typedef struct {
    logic [7:0] data;
    int         t0;
    int         n;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass    = 0;
  int   n_total   = 0;
  int   valid_cnt = 0;
  int   cyc       = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic monitor();
    logic valid_prev;
    exp_t e;
    int   lat, lat_exp;
    valid_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (Rx_VALID) begin
        valid_cnt++;
        n_total++;
        if (valid_prev !== 1'b0) $display("FAIL valid_width: Rx_VALID high 2 clks, required 1");
        else n_pass++;
        n_total++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_valid: got pulse with data %h, required none", Rx_DATA);
        end else begin
          n_pass++;
          e = exp_q.pop_front();
          n_total++;
          if (Rx_DATA !== e.data) $display("FAIL sb_data: got %h required %h", Rx_DATA, e.data);
          else n_pass++;
          n_total++;
          if ({Rx_PERROR, Rx_FERROR} !== 2'b00)
            $display("FAIL sb_flags: got perr=%b ferr=%b required 0 0", Rx_PERROR, Rx_FERROR);
          else n_pass++;
          lat     = cyc - e.t0 - 1;
          lat_exp = 2 + 168 * e.n;
          n_total++;
          if (lat < lat_exp - 1 || lat > lat_exp + 1)
            $display("FAIL sb_latency: got %0d clks required %0d", lat, lat_exp);
          else n_pass++;
        end
      end
      valid_prev = Rx_VALID;
    end
  endtask

  task automatic drive_bit(input logic b, input int n);
    RxD = b;
    repeat (16 * n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                            input int n, input bit expect_ok);
    @(negedge clk);
    RxD = 1'b0;
    if (expect_ok) exp_q.push_back('{d, cyc, n});
    repeat (16 * n) @(negedge clk);
    for (int i = 0; i < 8; i++) drive_bit(d[i], n);
    drive_bit(par, n);
    drive_bit(stop, n);
    RxD = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #100;
    n_total++;
    if (Rx_DATA !== 8'h00) $display("FAIL reset_data: got %h required 00", Rx_DATA);
    else n_pass++;
    n_total++;
    if (Rx_VALID !== 1'b0) $display("FAIL reset_valid: got %b required 0", Rx_VALID);
    else n_pass++;
    n_total++;
    if (Rx_PERROR !== 1'b0) $display("FAIL reset_perr: got %b required 0", Rx_PERROR);
    else n_pass++;
    n_total++;
    if (Rx_FERROR !== 1'b0) $display("FAIL reset_ferr: got %b required 0", Rx_FERROR);
    else n_pass++;
    @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_good_frame();
    int v0;
    v0 = valid_cnt;
    baud_select = 3'b111;
    send_frame(8'h78, 1'b0, 1'b1, 27, 1'b1);
    repeat (20) @(negedge clk);
    n_total++;
    if (valid_cnt - v0 !== 1) $display("FAIL good_pulses: got %0d required 1", valid_cnt - v0);
    else n_pass++;
    n_total++;
    if (Rx_DATA !== 8'h78) $display("FAIL good_data: got %h required 78", Rx_DATA);
    else n_pass++;
    baud_select = 3'b110;
    send_frame(8'h81, 1'b0, 1'b1, 54, 1'b1);
    repeat (20) @(negedge clk);
    n_total++;
    if (valid_cnt - v0 !== 2) $display("FAIL good57600_pulses: got %0d required 2", valid_cnt - v0);
    else n_pass++;
    n_total++;
    if (Rx_DATA !== 8'h81) $display("FAIL good57600_data: got %h required 81", Rx_DATA);
    else n_pass++;
    baud_select = 3'b111;
  endtask

  task automatic test_parity_error();
    int         v0;
    logic [7:0] d;
    v0 = valid_cnt;
    send_frame(8'h78, 1'b1, 1'b1, 27, 1'b0);
    repeat (20) @(negedge clk);
    n_total++;
    if (valid_cnt - v0 !== 0) $display("FAIL perr_pulses: got %0d required 0", valid_cnt - v0);
    else n_pass++;
    n_total++;
    if ({Rx_PERROR, Rx_FERROR} !== 2'b10)
      $display("FAIL perr_flags: got perr=%b ferr=%b required 1 0", Rx_PERROR, Rx_FERROR);
    else n_pass++;
    n_total++;
    if (Rx_DATA !== 8'h78) $display("FAIL perr_data: got %h required 78", Rx_DATA);
    else n_pass++;
    // Next good frame: the flag must drop once its start bit is confirmed.
    d = 8'h66;
    @(negedge clk);
    RxD = 1'b0;
    exp_q.push_back('{d, cyc, 27});
    repeat (16 * 27) @(negedge clk);
    n_total++;
    if (Rx_PERROR !== 1'b0) $display("FAIL perr_clear: got %b required 0", Rx_PERROR);
    else n_pass++;
    n_total++;
    if (Rx_DATA !== 8'h78) $display("FAIL data_hold: got %h required 78", Rx_DATA);
    else n_pass++;
    for (int i = 0; i < 8; i++) drive_bit(d[i], 27);
    drive_bit(1'b0, 27);
    drive_bit(1'b1, 27);
    repeat (20) @(negedge clk);
    n_total++;
    if (Rx_DATA !== 8'h66) $display("FAIL after_perr_data: got %h required 66", Rx_DATA);
    else n_pass++;
  endtask

  task automatic test_framing_error();
    int v0;
    v0 = valid_cnt;
    send_frame(8'hA5, 1'b0, 1'b0, 27, 1'b0);
    repeat (2 * 16 * 27) @(negedge clk);
    n_total++;
    if (valid_cnt - v0 !== 0) $display("FAIL ferr_pulses: got %0d required 0", valid_cnt - v0);
    else n_pass++;
    n_total++;
    if ({Rx_PERROR, Rx_FERROR} !== 2'b01)
      $display("FAIL ferr_flags: got perr=%b ferr=%b required 0 1", Rx_PERROR, Rx_FERROR);
    else n_pass++;
    n_total++;
    if (Rx_DATA !== 8'hA5) $display("FAIL ferr_data: got %h required A5", Rx_DATA);
    else n_pass++;
  endtask

  task automatic test_glitch();
    int v0;
    v0 = valid_cnt;
    baud_select = 3'b011;
    repeat (5) @(negedge clk);
    RxD = 1'b0;
    repeat (150) @(negedge clk);
    RxD = 1'b1;
    repeat (3000) @(negedge clk);
    n_total++;
    if (valid_cnt - v0 !== 0) $display("FAIL glitch_pulses: got %0d required 0", valid_cnt - v0);
    else n_pass++;
    n_total++;
    if ({Rx_DATA, Rx_PERROR, Rx_FERROR} !== {8'hA5, 2'b01})
      $display("FAIL glitch_outputs: got %h/%b/%b required A5/0/1", Rx_DATA, Rx_PERROR, Rx_FERROR);
    else n_pass++;
    baud_select = 3'b111;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int v0;
    v0 = valid_cnt;
    send_frame(8'h00, 1'b0, 1'b1, 27, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b1, 27, 1'b1);
    repeat (20) @(negedge clk);
    n_total++;
    if (valid_cnt - v0 !== 2) $display("FAIL b2b_pulses: got %0d required 2", valid_cnt - v0);
    else n_pass++;
    n_total++;
    if ({Rx_DATA, Rx_FERROR} !== {8'hFF, 1'b0})
      $display("FAIL b2b_final: got data=%h ferr=%b required FF 0", Rx_DATA, Rx_FERROR);
    else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    int         v0;
    logic [7:0] d;
    v0 = valid_cnt;
    d  = 8'h5A;
    @(negedge clk);
    RxD = 1'b0;
    repeat (16 * 27) @(negedge clk);
    for (int i = 0; i < 4; i++) drive_bit(d[i], 27);
    RxD = d[4];
    repeat (8 * 27) @(negedge clk);
    reset = 1'b0;
    #1;
    n_total++;
    if ({Rx_DATA, Rx_VALID, Rx_PERROR, Rx_FERROR} !== 11'h000)
      $display("FAIL midreset_outputs: got %h/%b/%b/%b required 00/0/0/0",
               Rx_DATA, Rx_VALID, Rx_PERROR, Rx_FERROR);
    else n_pass++;
    RxD = 1'b1;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    repeat (2 * 16 * 27) @(negedge clk);
    send_frame(8'h3C, 1'b0, 1'b1, 27, 1'b1);
    repeat (20) @(negedge clk);
    n_total++;
    if (valid_cnt - v0 !== 1) $display("FAIL postreset_pulses: got %0d required 1", valid_cnt - v0);
    else n_pass++;
    n_total++;
    if (Rx_DATA !== 8'h3C) $display("FAIL postreset_data: got %h required 3C", Rx_DATA);
    else n_pass++;
  endtask

  task automatic test_baud_change();
    int v0;
    v0 = valid_cnt;
    baud_select = 3'b111;
    fork
      send_frame(8'h5A, 1'b0, 1'b1, 27, 1'b1);
      begin
        repeat (3 * 16 * 27) @(negedge clk);
        baud_select = 3'b000;
      end
    join
    repeat (20) @(negedge clk);
    n_total++;
    if (valid_cnt - v0 !== 1) $display("FAIL baudchg_pulses: got %0d required 1", valid_cnt - v0);
    else n_pass++;
    n_total++;
    if (Rx_DATA !== 8'h5A) $display("FAIL baudchg_data: got %h required 5A", Rx_DATA);
    else n_pass++;
    baud_select = 3'b111;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_enable_abort();
    int         v0;
    logic [7:0] d;
    v0 = valid_cnt;
    d  = 8'hC3;
    @(negedge clk);
    RxD = 1'b0;
    repeat (16 * 27) @(negedge clk);
    for (int i = 0; i < 3; i++) drive_bit(d[i], 27);
    Rx_EN = 1'b0;
    for (int i = 3; i < 8; i++) drive_bit(d[i], 27);
    drive_bit(1'b0, 27);
    drive_bit(1'b1, 27);
    n_total++;
    if (valid_cnt - v0 !== 0) $display("FAIL abort_pulses: got %0d required 0", valid_cnt - v0);
    else n_pass++;
    n_total++;
    if ({Rx_DATA, Rx_PERROR, Rx_FERROR} !== {8'h5A, 2'b00})
      $display("FAIL abort_outputs: got %h/%b/%b required 5A/0/0", Rx_DATA, Rx_PERROR, Rx_FERROR);
    else n_pass++;
    Rx_EN = 1'b1;
    repeat (5) @(negedge clk);
    send_frame(d, 1'b0, 1'b1, 27, 1'b1);
    repeat (20) @(negedge clk);
    n_total++;
    if (Rx_DATA !== 8'hC3) $display("FAIL reenable_data: got %h required C3", Rx_DATA);
    else n_pass++;
  endtask

  initial begin
    RxD         = 1'b1;
    Rx_EN       = 1'b0;
    baud_select = 3'b011;
    reset       = 1'b0;
    fork
      monitor();
    join_none
    test_reset();
    Rx_EN = 1'b1;
    test_good_frame();
    test_parity_error();
    test_framing_error();
    test_glitch();
    test_back_to_back();
    test_reset_mid_frame();
    test_baud_change();
    test_enable_abort();
    repeat (100) @(negedge clk);
    n_total++;
    if (exp_q.size() !== 0) $display("FAIL sb_drain: %0d frames outstanding, required 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
